// File: rtl/step_tempo_scheduler.sv
// Step-sequencer timebase: clamps the incoming tempo, derives the step period
// with a 32-cycle restoring divider, and runs the play/stop FSM that emits
// step ticks and the running step index.
module step_tempo_scheduler #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int STEPS          = 16,
    parameter int STEPS_PER_BEAT = 4,
    parameter int BPM_MIN        = 30,
    parameter int BPM_MAX        = 300
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic [9:0] BPM,
    input  logic       play_toggle,
    input  logic       pos_reset,
    output logic       step_tick,
    output logic [3:0] step_idx,
    output logic       playing,
    output logic       div_busy,
    output logic [9:0] bpm_eff
);

    // state      | meaning
    // ST_STOPPED | idle, step index held at 0
    // ST_ARMED   | play requested, waiting for the first valid period
    // ST_PLAYING | counting steps and emitting ticks

    // Wide intermediate so CLK_HZ*60 cannot overflow a 32-bit int.
    localparam logic [63:0] NUM_W     = (64'(CLK_HZ) * 64'd60) / 64'(STEPS_PER_BEAT);
    localparam logic [31:0] NUM       = NUM_W[31:0];
    localparam logic [9:0]  BPM_LO    = 10'(BPM_MIN);
    localparam logic [9:0]  BPM_HI    = 10'(BPM_MAX);
    localparam logic [3:0]  STEP_LAST = 4'(STEPS - 1);

    typedef enum logic [1:0] {
        ST_STOPPED,
        ST_ARMED,
        ST_PLAYING
    } state_t;

    state_t      state_q;
    logic [9:0]  bpm_c;
    logic [9:0]  bpm_eff_q;
    logic        div_busy_q;
    logic [4:0]  div_cnt_q;
    logic [9:0]  rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [10:0] rem_shift, rem_diff;
    logic [31:0] period_q;
    logic        period_valid_q;
    logic [31:0] period_act_q;
    logic [31:0] tick_cnt_q;
    logic        tick_tc;
    logic        step_tick_q;
    logic [3:0]  step_idx_q;
    logic        playing_q;

    // Clamp the requested tempo into the supported range.
    always_comb begin
        bpm_c = BPM;
        if (BPM < BPM_LO) begin
            bpm_c = BPM_LO;
        end else if (BPM > BPM_HI) begin
            bpm_c = BPM_HI;
        end
    end

    // One restoring-division step; rem_diff[10] is the borrow because the
    // shifted remainder is always below twice the divisor.
    always_comb begin
        rem_shift = {rem_q, quo_q[31]};
        rem_diff  = rem_shift - {1'b0, bpm_eff_q};
        if (!rem_diff[10]) begin
            rem_d = rem_diff[9:0];
            quo_d = {quo_q[30:0], 1'b1};
        end else begin
            rem_d = rem_shift[9:0];
            quo_d = {quo_q[30:0], 1'b0};
        end
    end

    // Tempo change detect and divider sequencing; a running divide always completes.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            bpm_eff_q      <= '0;
            div_busy_q     <= 1'b0;
            div_cnt_q      <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
        end else if (div_busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (div_cnt_q == 5'd0) begin
                div_busy_q     <= 1'b0;
                period_q       <= quo_d;
                period_valid_q <= 1'b1;
            end else begin
                div_cnt_q <= div_cnt_q - 5'd1;
            end
        end else if (bpm_c != bpm_eff_q) begin
            bpm_eff_q  <= bpm_c;
            div_busy_q <= 1'b1;
            div_cnt_q  <= 5'd31;
            rem_q      <= '0;
            quo_q      <= NUM;
        end
    end

    assign tick_tc = (tick_cnt_q == period_act_q - 32'd1);

    // Play/stop FSM with step counter; the active period only reloads at step boundaries.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q      <= ST_STOPPED;
            tick_cnt_q   <= '0;
            period_act_q <= '0;
            step_idx_q   <= '0;
            step_tick_q  <= 1'b0;
            playing_q    <= 1'b0;
        end else begin
            step_tick_q <= 1'b0;
            case (state_q)
                ST_STOPPED: begin
                    if (play_toggle) begin
                        if (period_valid_q) begin
                            state_q      <= ST_PLAYING;
                            playing_q    <= 1'b1;
                            step_tick_q  <= 1'b1;
                            step_idx_q   <= '0;
                            tick_cnt_q   <= '0;
                            period_act_q <= period_q;
                        end else begin
                            state_q <= ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (play_toggle) begin
                        state_q <= ST_STOPPED;
                    end else if (period_valid_q) begin
                        state_q      <= ST_PLAYING;
                        playing_q    <= 1'b1;
                        step_tick_q  <= 1'b1;
                        step_idx_q   <= '0;
                        tick_cnt_q   <= '0;
                        period_act_q <= period_q;
                    end
                end
                ST_PLAYING: begin
                    if (play_toggle) begin
                        state_q    <= ST_STOPPED;
                        playing_q  <= 1'b0;
                        step_idx_q <= '0;
                        tick_cnt_q <= '0;
                    end else if (pos_reset || tick_tc) begin
                        tick_cnt_q  <= '0;
                        step_tick_q <= 1'b1;
                        if (pos_reset || step_idx_q == STEP_LAST) begin
                            step_idx_q <= '0;
                        end else begin
                            step_idx_q <= step_idx_q + 4'd1;
                        end
                        if (tick_tc) begin
                            period_act_q <= period_q;
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= ST_STOPPED;
                end
            endcase
        end
    end

    assign step_tick = step_tick_q;
    assign step_idx  = step_idx_q;
    assign playing   = playing_q;
    assign div_busy  = div_busy_q;
    assign bpm_eff   = bpm_eff_q;

endmodule

// File: tb/tb_step_tempo_scheduler.sv
// Bench for step_tempo_scheduler with a small clock (NUM = 15000) so periods
// stay short: 120 BPM -> 125 cycles, 30 -> 500, 300 -> 50.
module tb_step_tempo_scheduler;

    localparam int CLK_HZ = 1000;
    localparam int STEPS  = 16;
    localparam int SPB    = 4;
    localparam int BMIN   = 30;
    localparam int BMAX   = 300;
    localparam int NUM    = CLK_HZ * 60 / SPB;

    logic       Clock = 1'b0;
    logic       nReset = 1'b0;
    logic [9:0] BPM = 10'd120;
    logic       play_toggle = 1'b0;
    logic       pos_reset = 1'b0;
    logic       step_tick;
    logic [3:0] step_idx;
    logic       playing;
    logic       div_busy;
    logic [9:0] bpm_eff;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    step_tempo_scheduler #(
        .CLK_HZ(CLK_HZ), .STEPS(STEPS), .STEPS_PER_BEAT(SPB),
        .BPM_MIN(BMIN), .BPM_MAX(BMAX)
    ) dut (
        .Clock(Clock), .nReset(nReset), .BPM(BPM),
        .play_toggle(play_toggle), .pos_reset(pos_reset),
        .step_tick(step_tick), .step_idx(step_idx), .playing(playing),
        .div_busy(div_busy), .bpm_eff(bpm_eff)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Behavioural model: divider as "busy for 32 cycles then NUM/bpm",
    // playback as absolute cycle numbers of the next step boundary.
    int m_bpm_eff = 0, m_busy_left = 0, m_period = 0;
    bit m_pvalid = 0;
    int m_state = 0;            // 0 stopped, 1 armed, 2 playing
    int m_step = 0, m_len = 0, m_next = 0;
    bit m_tick = 0;

    function automatic int clampf(int b);
        if (b < BMIN) return BMIN;
        if (b > BMAX) return BMAX;
        return b;
    endfunction

    always @(posedge Clock) begin
        int old_period;
        bit old_pv;
        bit wrap;
        old_period = m_period;
        old_pv     = m_pvalid;
        if (!nReset) begin
            m_bpm_eff = 0; m_busy_left = 0; m_period = 0; m_pvalid = 0;
            m_state = 0; m_step = 0; m_len = 0; m_next = 0; m_tick = 0;
        end else begin
            m_tick = 0;
            case (m_state)
                0: if (play_toggle) begin
                    if (old_pv) begin
                        m_state = 2; m_tick = 1; m_step = 0;
                        m_len = old_period; m_next = cyc + m_len;
                    end else begin
                        m_state = 1;
                    end
                end
                1: if (play_toggle) begin
                    m_state = 0;
                end else if (old_pv) begin
                    m_state = 2; m_tick = 1; m_step = 0;
                    m_len = old_period; m_next = cyc + m_len;
                end
                default: if (play_toggle) begin
                    m_state = 0; m_step = 0;
                end else begin
                    wrap = (cyc == m_next);
                    if (wrap) m_len = old_period;
                    if (wrap || pos_reset) begin
                        m_tick = 1;
                        m_step = pos_reset ? 0 : (m_step + 1) % STEPS;
                        m_next = cyc + m_len;
                    end
                end
            endcase
            if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) begin
                    m_period = NUM / m_bpm_eff;
                    m_pvalid = 1;
                end
            end else if (clampf(int'(BPM)) != m_bpm_eff) begin
                m_bpm_eff   = clampf(int'(BPM));
                m_busy_left = 32;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge Clock) begin
        if (cyc > 0) begin
            n_checks++;
            if (step_tick !== m_tick || step_idx !== 4'(m_step) ||
                playing !== (m_state == 2) || div_busy !== (m_busy_left > 0) ||
                bpm_eff !== 10'(m_bpm_eff)) begin
                n_errors++;
                $display("FAIL model cyc=%0d tick=%b/%b idx=%0d/%0d playing=%b/%b busy=%b/%b bpm_eff=%0d/%0d (actual/required)",
                         cyc, step_tick, m_tick, step_idx, m_step, playing, (m_state == 2),
                         div_busy, (m_busy_left > 0), bpm_eff, m_bpm_eff);
            end
        end
    end

    // Tick and busy-run monitors for the directed checks.
    int tick_count = 0, last_tick = -1, prev_tick = -1;
    int busy_run = 0, last_busy_run = 0, busy_fall = -1;
    always @(negedge Clock) begin
        if (step_tick === 1'b1) begin
            prev_tick = last_tick; last_tick = cyc; tick_count++;
        end
        if (div_busy === 1'b1) begin
            busy_run++;
        end else begin
            if (busy_run > 0) begin
                last_busy_run = busy_run; busy_fall = cyc;
            end
            busy_run = 0;
        end
    end

    task automatic step();
        @(negedge Clock);
        #1;
    endtask

    task automatic steps(int n);
        repeat (n) step();
    endtask

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic pulse_toggle();
        play_toggle = 1'b1;
        step();
        play_toggle = 1'b0;
    endtask

    task automatic wait_tick(string name, int limit);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (step_tick !== 1'b1 && n < limit);
        if (step_tick !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s no tick within %0d cycles", name, n);
        end
    endtask

    initial begin
        int tc;
        nReset = 1'b0; BPM = 10'd120;
        steps(3);
        check("reset_outputs", int'({step_tick, step_idx, playing, div_busy, bpm_eff}), 0);

        nReset = 1'b1;
        step();
        check("busy_after_release", int'(div_busy), 1);
        check("bpm_eff_120", int'(bpm_eff), 120);
        pulse_toggle();
        check("armed_not_playing", int'(playing), 0);
        wait_tick("armed_first_tick", 100);
        check("busy_len", last_busy_run, 32);
        check("tick_after_valid", last_tick - busy_fall, 1);
        check("first_idx", int'(step_idx), 0);
        check("model_period_120", m_period, 125);

        wait_tick("tick2", 200);
        check("interval_120", last_tick - prev_tick, 125);
        check("idx1", int'(step_idx), 1);
        repeat (14) wait_tick("run", 200);
        check("idx15", int'(step_idx), 15);
        wait_tick("wrap", 200);
        check("idx_wrap", int'(step_idx), 0);

        repeat (7) wait_tick("to7", 200);
        check("idx7", int'(step_idx), 7);
        steps(20);
        pos_reset = 1'b1;
        step();
        pos_reset = 1'b0;
        check("posrst_tick", int'(step_tick), 1);
        check("posrst_idx", int'(step_idx), 0);
        wait_tick("after_posrst", 200);
        check("interval_posrst", last_tick - prev_tick, 125);

        steps(10);
        BPM = 10'd300;
        wait_tick("mid_change", 200);
        check("step_kept_125", last_tick - prev_tick, 125);
        check("bpm_eff_300", int'(bpm_eff), 300);
        wait_tick("fast1", 200);
        check("interval_50", last_tick - prev_tick, 50);

        pulse_toggle();
        check("stop_playing", int'(playing), 0);
        check("stop_idx", int'(step_idx), 0);
        check("stop_no_tick", int'(step_tick), 0);

        BPM = 10'd10;
        step();
        check("bpm_eff_clamp_lo", int'(bpm_eff), 30);
        steps(5);
        BPM = 10'd120;
        steps(5);
        BPM = 10'd999;
        steps(80);
        check("bpm_eff_last", int'(bpm_eff), 300);
        check("busy_settled", int'(div_busy), 0);
        check("model_period_300", m_period, 50);

        pulse_toggle();
        check("play_tick", int'(step_tick), 1);
        check("play_idx", int'(step_idx), 0);
        wait_tick("play50", 100);
        check("interval_after_busy_changes", last_tick - prev_tick, 50);

        BPM = 10'd0;
        steps(40);
        check("bpm_eff_zero", int'(bpm_eff), 30);
        wait_tick("slow0", 100);
        check("interval_before_slow", last_tick - prev_tick, 50);
        wait_tick("slow1", 600);
        check("interval_500", last_tick - prev_tick, 500);

        BPM = 10'd999;
        steps(40);
        check("bpm_eff_999", int'(bpm_eff), 300);

        play_toggle = 1'b1; pos_reset = 1'b1;
        step();
        play_toggle = 1'b0; pos_reset = 1'b0;
        check("both_playing", int'(playing), 0);
        check("both_idx", int'(step_idx), 0);
        check("both_no_tick", int'(step_tick), 0);

        pulse_toggle();
        repeat (3) wait_tick("pre_reset", 600);
        steps(10);
        nReset = 1'b0;
        step();
        check("midplay_reset", int'({step_tick, step_idx, playing, div_busy, bpm_eff}), 0);

        nReset = 1'b1;
        step();
        pulse_toggle();
        steps(3);
        pulse_toggle();
        tc = tick_count;
        steps(60);
        check("armed_cancel_no_tick", tick_count - tc, 0);
        check("armed_cancel_playing", int'(playing), 0);
        check("armed_cancel_bpm", int'(bpm_eff), 300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
